// File: rtl/minicalc_pkg.sv
// Shared opcode constants, FSM state encoding and the button priority helper
// for the minicalc sequencer.
package minicalc_pkg;

  localparam logic [1:0] OP_ADDSUB = 2'd0;
  localparam logic [1:0] OP_MINMAX = 2'd1;
  localparam logic [1:0] OP_MUL    = 2'd2;
  localparam logic [1:0] OP_DIV    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Lowest-index pressed button wins: btn0 > btn1 > btn2 > btn3.
  function automatic logic [1:0] pick_op(input logic [3:0] edges);
    logic [1:0] op;
    if (edges[0])      op = OP_ADDSUB;
    else if (edges[1]) op = OP_MINMAX;
    else if (edges[2]) op = OP_MUL;
    else               op = OP_DIV;
    return op;
  endfunction

endpackage

// File: rtl/minicalc_div_serial.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
// The quotient/remainder outputs present the result of the step being taken
// on the coming edge, so they are valid while done is high and can be
// registered by the parent on that same edge.
module minicalc_div_serial
  import minicalc_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            done
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;

  logic [BITS-1:0]  rem_q;
  logic [BITS-1:0]  quo_q;
  logic [BITS-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  logic [BITS:0]    shifted;
  logic [BITS:0]    trial;
  logic [BITS:0]    quo_shift;
  logic             fits;
  logic [BITS-1:0]  rem_next;
  logic [BITS-1:0]  quo_next;

  // One restoring step: shift in the next dividend bit, try the subtract,
  // keep it only if it did not borrow.
  always_comb begin
    shifted   = {rem_q, quo_q[BITS-1]};
    trial     = shifted - {1'b0, dvs_q};
    fits      = ~trial[BITS];
    rem_next  = fits ? trial[BITS-1:0] : shifted[BITS-1:0];
    quo_shift = {quo_q, fits};
    quo_next  = quo_shift[BITS-1:0];
  end

  assign quotient  = quo_next;
  assign remainder = rem_next;
  assign done      = active_q && (cnt_q == '0);

  // Load operands on start, then iterate with the counter running BITS-1 down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= CNT_W'(BITS - 1);
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/minicalc_seq.sv
// minicalc sequencer: synchronises and edge-detects the buttons, latches the
// operands on a press, runs the selected operation and holds the result on led.
module minicalc_seq
  import minicalc_pkg::*;
#(
  parameter int BITS        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*BITS-1:0] sw,
  input  logic [3:0]        btn,
  output logic [2*BITS-1:0] led,
  output logic              busy,
  output logic              done
);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]      prev_q;
  logic [3:0]      synced;
  logic [3:0]      btn_edge;
  logic            accept;
  logic [1:0]      op_sel;

  state_t          state_q;
  state_t          state_d;

  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic [1:0]      op_q;

  logic [2*BITS-1:0] alu_result;
  logic [2*BITS-1:0] product;

  logic            div_start;
  logic            div_done;
  logic [BITS-1:0] div_quo;
  logic [BITS-1:0] div_rem;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign btn_edge = synced & ~prev_q;
  assign accept   = ((state_q == IDLE) || (state_q == HOLD)) && (|btn_edge);
  assign op_sel   = pick_op(btn_edge);
  assign busy     = (state_q == EXEC) || (state_q == DIV);

  // Button synchroniser chain plus the previous-value register for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= synced;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: presses only accepted while idle or holding a result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: if (accept) state_d = (op_sel == OP_DIV) ? DIV : EXEC;
      EXEC:       state_d = HOLD;
      DIV:        if (div_done) state_d = HOLD;
      default:    state_d = IDLE;
    endcase
  end

  // Single-cycle operations on the latched operands.
  always_comb begin
    product    = {{BITS{1'b0}}, a_q} * {{BITS{1'b0}}, b_q};
    alu_result = '0;
    case (op_q)
      OP_ADDSUB: alu_result = {a_q + b_q, a_q - b_q};
      OP_MINMAX: alu_result = (b_q < a_q) ? {b_q, a_q} : {a_q, b_q};
      OP_MUL:    alu_result = product;
      default:   alu_result = '0;
    endcase
  end

  // The divider takes its operands straight from sw on the accepting edge,
  // the same edge that latches them locally.
  assign div_start = accept && (op_sel == OP_DIV);

  minicalc_div_serial #(.BITS(BITS)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (sw[2*BITS-1:BITS]),
    .divisor   (sw[BITS-1:0]),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Operand/opcode latch on acceptance; result and done pulse on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADDSUB;
      led  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q  <= sw[2*BITS-1:BITS];
        b_q  <= sw[BITS-1:0];
        op_q <= op_sel;
      end
      if (state_q == EXEC) begin
        led  <= alu_result;
        done <= 1'b1;
      end else if ((state_q == DIV) && div_done) begin
        led  <= {div_quo, div_rem};
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_minicalc_seq.sv
// Directed bench for minicalc_seq (BITS=4) with hand-computed expectations.
module tb_minicalc_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] led;
  logic       busy;
  logic       done;

  int checks;
  int fails;
  int done_cnt;
  int busy_cnt;

  minicalc_seq #(.BITS(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Press b with sw=s; once busy is first seen, switch sw to s_busy and add
  // b_busy to the held buttons. Counts done pulses and busy cycles.
  task automatic press(input logic [3:0] b, input logic [7:0] s,
                       input logic [7:0] s_busy, input logic [3:0] b_busy);
    bit seen;
    seen     = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    sw  = s;
    btn = b;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) begin
        busy_cnt++;
        if (!seen) begin
          seen = 1'b1;
          sw   = s_busy;
          btn  = b | b_busy;
        end
      end
    end
    btn = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic simple(input string tag, input logic [3:0] b, input logic [7:0] s,
                        input logic [7:0] exp_led, input int exp_busy);
    press(b, s, s, 4'h0);
    check({tag, "_led"},  led, exp_led);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_busy"}, busy_cnt, exp_busy);
  endtask

  initial begin
    int waited;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b1;
    sw     = 8'h00;
    btn    = 4'h0;

    // Asynchronous reset before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("reset_led",  led,  8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Add/sub, then hold stability
    simple("addsub", 4'h1, 8'h35, 8'h8E, 1);
    repeat (20) @(negedge clk);
    check("hold_led",  led,  8'h8E);
    check("hold_busy", busy, 1'b0);
    check("hold_done", done, 1'b0);

    // Min/max
    simple("minmax_72", 4'h2, 8'h72, 8'h27, 1);
    simple("minmax_27", 4'h2, 8'h27, 8'h27, 1);
    simple("minmax_55", 4'h2, 8'h55, 8'h55, 1);

    // Multiply
    simple("mul_ff", 4'h4, 8'hFF, 8'hE1, 1);
    simple("mul_00", 4'h4, 8'h00, 8'h00, 1);

    // Simultaneous btn0 + btn2: btn0 wins
    simple("prio", 4'h5, 8'h35, 8'h8E, 1);

    // Divide, then divide with sw changed while busy
    simple("div_d3", 4'h8, 8'hD3, 8'h41, 4);
    press(4'h8, 8'hD3, 8'h00, 4'h0);
    check("div_swchg_led",  led, 8'h41);
    check("div_swchg_done", done_cnt, 1);

    // Divide by zero, with btn0 pressed during the divide
    simple("div_zero", 4'h8, 8'h90, 8'hF9, 4);
    press(4'h8, 8'h90, 8'h90, 4'h1);
    check("div_ignore_led",  led, 8'hF9);
    check("div_ignore_done", done_cnt, 1);
    check("div_ignore_busy", busy_cnt, 4);

    // Reset in the middle of a divide
    sw  = 8'hF2;
    btn = 4'h8;
    waited = 0;
    while (!busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("abort_busy_seen", busy, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_led",  led,  8'h00);
    check("abort_busy", busy, 1'b0);
    btn = 4'h0;
    repeat (3) @(negedge clk);
    check("abort_hold_led", led, 8'h00);
    check("abort_idle",     dut.state_q, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_retrigger", busy, 1'b0);

    simple("div_f2", 4'h8, 8'hF2, 8'h71, 4);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/minicalc_seq.md
Name: minicalc_seq

Overview:
- Clocked sequencer for the minicalc arithmetic datapath: add/sub, min/max ordering, multiply, divide/modulo on two BITS-wide operands taken from sw.
- Synchronises and edge-detects btn, latches operands and opcode on a press, and runs single-cycle ops or a BITS-cycle serial restoring divide.
- Holds the result on led until the next accepted press.
- Sits between board switches/buttons and the LED bank; replaces the level-sensitive combinational calculator.

Parameters:
BITS, 4, operand width; sw and led are 2*BITS wide
SYNC_STAGES, 2, flip-flop stages in the btn synchroniser (min 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  2*BITS  operands: A = sw[2*BITS-1:BITS], B = sw[BITS-1:0]
btn  input  4  raw asynchronous push buttons, op select
led  output  2*BITS  registered result
busy  output  1  high while an operation is executing
done  output  1  one-cycle pulse in the cycle led takes a new value

Behaviour:
- Reset, asynchronous on rst_n low: led=0, busy=0, done=0, FSM=IDLE, synchroniser/prev regs=0, operand/op regs=0. Reset mid-divide aborts with no partial result.
- Input path: btn passes SYNC_STAGES flops; prev register holds last synced value; edge = synced & ~prev per bit.
- Press acceptance: only in IDLE or HOLD. If any edge bit is set, op = lowest-index set bit (btn0 > btn1 > btn2 > btn3).
  - Same clock edge: A and B latched from sw, op latched.
  - Edges arriving in EXEC/DIV are discarded, not queued.
  - Held buttons never retrigger.
- FSM: IDLE -> (accept, op!=div) EXEC | (accept, div) DIV; EXEC -> HOLD; DIV -> HOLD after BITS iterations; HOLD -> same accept rules as IDLE.
- busy = 1 in EXEC and DIV. done pulses on the edge leaving EXEC or the final DIV iteration.
- Latency, counted from the clock edge of acceptance:
  - Single-cycle ops: led updates 1 edge later.
  - Divide: led updates BITS edges later.
  - Operand changes on sw after acceptance have no effect.
- Operations, all results mod 2^BITS per field:
  - btn0: led = {A+B, A-B}, both truncated; borrow dropped (two's-complement wrap).
  - btn1: led = {min(A,B), max(A,B)}; A==B gives {A,B}.
  - btn2: led = A*B, full 2*BITS-bit product.
  - btn3: led = {A/B, A%B}, serial restoring division, MSB first, one quotient bit per cycle, counter BITS-1 down to 0.
- Divide by zero: no special case. Every trial subtract succeeds, so quotient = all ones and remainder = A.
- HOLD: led, busy=0 and done=0 stay stable indefinitely.

Decomposition:
- Shared package minicalc_pkg:
  - opcode constants OP_ADDSUB, OP_MINMAX, OP_MUL, OP_DIV (2-bit)
  - FSM state encoding IDLE, EXEC, DIV, HOLD
- One sub-module, minicalc_div_serial (BITS parameter): ports clk, rst_n, start, dividend, divisor, quotient, remainder, done. Holds the remainder/quotient shift registers and the iteration counter.
- Synchroniser and edge detect stay inline.

Test Plan (BITS=4; each press held several cycles, then released):
- Reset with rst_n low mid-cycle -> led=0x00, busy=0 immediately (no clock needed). sw=0x35, press btn0 -> led=0x8E one edge after acceptance, done pulse exactly once, led still 0x8E 20 cycles after release.
- sw=0x72, btn1 -> led=0x27. Then sw=0x27, btn1 -> 0x27. Then sw=0x55, btn1 -> 0x55.
- sw=0xFF, btn2 -> 0xE1. sw=0x00, btn2 -> 0x00. Simultaneous btn0+btn2 edges with sw=0x35 -> 0x8E (btn0 priority).
- sw=0xD3, btn3 -> busy high exactly 4 cycles, led=0x41 after 4 edges. Changing sw during busy -> still 0x41.
- sw=0x90, btn3 -> 0xF9 (divide by zero). btn0 pressed during that divide -> ignored; led ends 0xF9 with a single done pulse.
- Start divide sw=0xF2, btn3; assert rst_n low after 2 iterations -> led=0, IDLE. Post-reset press btn3 with sw=0xF2 -> 0x71.
